sram_dp_cfg: RTL and testbench

- Parametrised true dual-port synchronous SRAM; successor to the fixed 16K x 32 byte-masked dual-port array used as instruction/data memory.
- Adds configurable width and depth, per-port request/valid handshake, and a selectable read-during-write mode.
- Adds an optional output register stage, deterministic write-write collision resolution, and a post-reset clear sequencer that zeroes the array.
- Sits between the LSU/fetch units and the memory map; both ports are symmetric.

---
 rtl/sram_dp_cfg_pkg.sv | 21 ++
 rtl/sram_dp_cfg_if.sv | 18 +
 rtl/sram_dp_cfg_rd_pipe.sv | 51 +++++
 rtl/sram_dp_cfg.sv | 129 ++++++++++++
 tb/tb_sram_dp_cfg.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_dp_cfg_pkg.sv
// Shared types and helpers for the configurable dual-port SRAM.
package sram_pkg;

    typedef enum logic [1:0] {
        RD_FIRST  = 2'd0,
        WR_FIRST  = 2'd1,
        NO_CHANGE = 2'd2
    } rd_mode_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } sram_state_e;

    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       en);
        return en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/sram_dp_cfg_if.sv
// One SRAM access port: request side driven by the client, read return driven by the array.
interface sram_dp_cfg_if #(
    parameter int DW = 32,
    parameter int AW = 14
);
    localparam int NB = DW / 8;

    logic          req;
    logic          wren;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [NB-1:0] bmask;
    logic [DW-1:0] rdata;
    logic          rvalid;

    modport master (output req, wren, addr, wdata, bmask, input rdata, rvalid);
    modport slave  (input req, wren, addr, wdata, bmask, output rdata, rvalid);
endinterface

// File: rtl/sram_dp_cfg_rd_pipe.sv
// Read-return output stage for one port; optional second register for timing closure.
module sram_rd_pipe #(
    parameter int DW      = 32,
    parameter int OUT_REG = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          vld_p0,
    input  logic [DW-1:0] data_p0,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);
    logic          vld_p1;
    logic [DW-1:0] data_p1;

    // p0 -> p1: data only loads on a valid return so the output holds otherwise
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0)
                data_p1 <= data_p0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          vld_p2;
            logic [DW-1:0] data_p2;

            // p1 -> p2
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    vld_p2  <= 1'b0;
                    data_p2 <= '0;
                end else begin
                    vld_p2  <= vld_p1;
                    data_p2 <= data_p1;
                end
            end

            assign rdata  = data_p2;
            assign rvalid = vld_p2;
        end else begin : g_no_out_reg
            assign rdata  = data_p1;
            assign rvalid = vld_p1;
        end
    endgenerate
endmodule

// File: rtl/sram_dp_cfg.sv
// True dual-port byte-masked SRAM with post-reset zero fill and same-address write arbitration.
module sram_dp_cfg
    import sram_pkg::*;
#(
    parameter int DW             = 32,
    parameter int DEPTH          = 16384,
    parameter int RD_MODE        = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    sram_dp_cfg_if.slave  port_a,
    sram_dp_cfg_if.slave  port_b,
    output logic          ready,
    output logic          collision
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DW / 8;
    localparam rd_mode_e    MODE    = rd_mode_e'(2'(RD_MODE));
    localparam sram_state_e ST_INIT = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    logic [DW-1:0] mem [DEPTH];

    sram_state_e   state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          ready_nxt;
    logic          clr_we;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_INIT;
            cnt   <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ready <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (cnt == AW'(DEPTH - 1))
                    state_nxt = ST_RUN;
                else
                    cnt_nxt = cnt + AW'(1);
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
        endcase
        ready_nxt = (state_nxt == ST_RUN);
    end

    logic acc_a, acc_b, we_a, we_b;

    assign acc_a = port_a.req & ready;
    assign acc_b = port_b.req & ready;
    assign we_a  = acc_a & port_a.wren;
    assign we_b  = acc_b & port_b.wren;

    // Port B bytes are assigned first so port A overrides overlapping bytes.
    always_ff @(posedge i_clk) begin
        if (clr_we) begin
            mem[cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++)
                if (we_b && port_b.bmask[i])
                    mem[port_b.addr][8*i +: 8] <= port_b.wdata[8*i +: 8];
            for (int i = 0; i < NB; i++)
                if (we_a && port_a.bmask[i])
                    mem[port_a.addr][8*i +: 8] <= port_a.wdata[8*i +: 8];
        end
    end

    logic [DW-1:0] old_a, old_b, merged_a, merged_b;
    logic [DW-1:0] data_p0_a, data_p0_b;
    logic          vld_p0_a, vld_p0_b;

    assign old_a = mem[port_a.addr];
    assign old_b = mem[port_b.addr];

    always_comb begin
        merged_a = old_a;
        merged_b = old_b;
        for (int i = 0; i < NB; i++) begin
            merged_a[8*i +: 8] = byte_merge(old_a[8*i +: 8], port_a.wdata[8*i +: 8], port_a.bmask[i]);
            merged_b[8*i +: 8] = byte_merge(old_b[8*i +: 8], port_b.wdata[8*i +: 8], port_b.bmask[i]);
        end
    end

    // p0: return word selected at acceptance; the other port's same-cycle write is never visible
    assign data_p0_a = (MODE == WR_FIRST && port_a.wren) ? merged_a : old_a;
    assign data_p0_b = (MODE == WR_FIRST && port_b.wren) ? merged_b : old_b;
    assign vld_p0_a  = acc_a & (~port_a.wren | (MODE != NO_CHANGE));
    assign vld_p0_b  = acc_b & (~port_b.wren | (MODE != NO_CHANGE));

    sram_rd_pipe #(.DW(DW), .OUT_REG(OUT_REG)) u_pipe_a (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .vld_p0  (vld_p0_a),
        .data_p0 (data_p0_a),
        .rdata   (port_a.rdata),
        .rvalid  (port_a.rvalid)
    );

    sram_rd_pipe #(.DW(DW), .OUT_REG(OUT_REG)) u_pipe_b (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .vld_p0  (vld_p0_b),
        .data_p0 (data_p0_b),
        .rdata   (port_b.rdata),
        .rvalid  (port_b.rvalid)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            collision <= 1'b0;
        else
            collision <= we_a & we_b & (port_a.addr == port_b.addr) &
                         (|(port_a.bmask & port_b.bmask));
    end
endmodule

// File: tb/tb_sram_dp_cfg.sv
// Bench for sram_dp_cfg: three instances (read-first, write-first with output register, no-change).
module tb_sram_dp_cfg;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req_a, wren_a, req_b, wren_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] wdata_a, wdata_b;
    logic [3:0]    bmask_a, bmask_b;

    logic [2:0]    rv_a, rv_b, rdy, col;
    logic [DW-1:0] rd_a [3];
    logic [DW-1:0] rd_b [3];

    // Instance g: RD_MODE = g; instance 1 also has the output register (latency 2).
    for (genvar g = 0; g < 3; g++) begin : gd
        sram_dp_cfg_if #(.DW(DW), .AW(AW)) ia ();
        sram_dp_cfg_if #(.DW(DW), .AW(AW)) ib ();

        assign ia.req   = req_a;
        assign ia.wren  = wren_a;
        assign ia.addr  = addr_a;
        assign ia.wdata = wdata_a;
        assign ia.bmask = bmask_a;
        assign ib.req   = req_b;
        assign ib.wren  = wren_b;
        assign ib.addr  = addr_b;
        assign ib.wdata = wdata_b;
        assign ib.bmask = bmask_b;
        assign rv_a[g]  = ia.rvalid;
        assign rv_b[g]  = ib.rvalid;
        assign rd_a[g]  = ia.rdata;
        assign rd_b[g]  = ib.rdata;

        sram_dp_cfg #(
            .DW(DW), .DEPTH(DEPTH), .RD_MODE(g), .OUT_REG(g == 1 ? 1 : 0), .CLEAR_ON_RESET(1)
        ) u_dut (
            .i_clk     (clk),
            .i_reset   (rst),
            .port_a    (ia),
            .port_b    (ib),
            .ready     (rdy[g]),
            .collision (col[g])
        );
    end

    // Reference model: word array plus expected outputs after each clock edge.
    logic [DW-1:0] mmem [DEPTH];
    int            clear_left;
    bit            m_ready;
    bit            ev [3][2];
    logic [DW-1:0] ed [3][2];
    bit            pv [2];
    logic [DW-1:0] pd [2];
    bit            ecol;

    task automatic model_reset();
        clear_left = DEPTH;
        m_ready    = 0;
        ecol       = 0;
        for (int d = 0; d < 3; d++)
            for (int x = 0; x < 2; x++) begin
                ev[d][x] = 0;
                ed[d][x] = '0;
            end
        for (int x = 0; x < 2; x++) begin
            pv[x] = 0;
            pd[x] = '0;
        end
    endtask

    task automatic model_edge();
        bit            acc [2];
        bit            wr [2];
        logic [DW-1:0] oldw [2];
        logic [DW-1:0] neww [2];
        bit            nv;
        logic [DW-1:0] nd;
        if (rst) begin
            model_reset();
            return;
        end
        acc[0] = req_a && m_ready;
        acc[1] = req_b && m_ready;
        wr[0]  = wren_a;
        wr[1]  = wren_b;
        oldw[0] = mmem[addr_a];
        oldw[1] = mmem[addr_b];
        neww[0] = oldw[0];
        neww[1] = oldw[1];
        for (int i = 0; i < 4; i++) begin
            if (bmask_a[i]) neww[0][8*i +: 8] = wdata_a[8*i +: 8];
            if (bmask_b[i]) neww[1][8*i +: 8] = wdata_b[8*i +: 8];
        end
        for (int d = 0; d < 3; d++)
            for (int x = 0; x < 2; x++) begin
                nv = acc[x] && (!wr[x] || d != 2);
                nd = (wr[x] && d == 1) ? neww[x] : oldw[x];
                if (d == 1) begin
                    ev[d][x] = pv[x];
                    if (pv[x]) ed[d][x] = pd[x];
                    pv[x] = nv;
                    if (nv) pd[x] = nd;
                end else begin
                    ev[d][x] = nv;
                    if (nv) ed[d][x] = nd;
                end
            end
        ecol = acc[0] && acc[1] && wr[0] && wr[1] && (addr_a == addr_b) && ((bmask_a & bmask_b) != 0);
        if (clear_left > 0) begin
            mmem[DEPTH - clear_left] = '0;
            clear_left--;
            if (clear_left == 0) m_ready = 1;
        end else begin
            if (acc[1] && wr[1])
                for (int i = 0; i < 4; i++)
                    if (bmask_b[i]) mmem[addr_b][8*i +: 8] = wdata_b[8*i +: 8];
            if (acc[0] && wr[0])
                for (int i = 0; i < 4; i++)
                    if (bmask_a[i]) mmem[addr_a][8*i +: 8] = wdata_a[8*i +: 8];
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        req_a = 0; wren_a = 0; addr_a = '0; wdata_a = '0; bmask_a = '0;
        req_b = 0; wren_b = 0; addr_b = '0; wdata_b = '0; bmask_b = '0;
    endtask

    task automatic set_a(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd, input logic [3:0] m);
        req_a = 1; wren_a = w; addr_a = ad; wdata_a = wd; bmask_a = m;
    endtask

    task automatic set_b(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd, input logic [3:0] m);
        req_b = 1; wren_b = w; addr_b = ad; wdata_b = wd; bmask_b = m;
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rdy[d] !== 1'b0 || col[d] !== 1'b0 || rv_a[d] !== 1'b0 || rv_b[d] !== 1'b0 ||
                rd_a[d] !== '0 || rd_b[d] !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: rdy=%b col=%b rva=%b rvb=%b rda=%h rdb=%h, want all zero",
                         d, rdy[d], col[d], rv_a[d], rv_b[d], rd_a[d], rd_b[d]);
            end
        end
        step();
        step();
        rst = 0;
        n = 0;
        while (rdy[0] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL reset_clear_len: ready low for %0d cycles, want %0d", n, DEPTH);
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rdy[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready dut%0d: got %b want 1", d, rdy[d]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_a   = ($urandom_range(0, 3) != 0);
            wren_a  = $urandom_range(0, 1);
            addr_a  = AW'($urandom_range(0, DEPTH - 1));
            wdata_a = $urandom;
            bmask_a = 4'($urandom_range(0, 15));
            req_b   = ($urandom_range(0, 3) != 0);
            wren_b  = $urandom_range(0, 1);
            addr_b  = ($urandom_range(0, 3) == 0) ? addr_a : AW'($urandom_range(0, DEPTH - 1));
            wdata_b = $urandom;
            bmask_b = 4'($urandom_range(0, 15));
            step();
            for (int d = 0; d < 3; d++) begin
                checks += 6;
                if (rdy[d] !== m_ready) begin
                    errors++;
                    $display("FAIL rand_ready dut%0d cyc%0d: got %b want %b", d, c, rdy[d], m_ready);
                end
                if (col[d] !== ecol) begin
                    errors++;
                    $display("FAIL rand_collision dut%0d cyc%0d: got %b want %b", d, c, col[d], ecol);
                end
                if (rv_a[d] !== ev[d][0]) begin
                    errors++;
                    $display("FAIL rand_rvalid_a dut%0d cyc%0d: got %b want %b", d, c, rv_a[d], ev[d][0]);
                end
                if (rd_a[d] !== ed[d][0]) begin
                    errors++;
                    $display("FAIL rand_rdata_a dut%0d cyc%0d: got %h want %h", d, c, rd_a[d], ed[d][0]);
                end
                if (rv_b[d] !== ev[d][1]) begin
                    errors++;
                    $display("FAIL rand_rvalid_b dut%0d cyc%0d: got %b want %b", d, c, rv_b[d], ev[d][1]);
                end
                if (rd_b[d] !== ed[d][1]) begin
                    errors++;
                    $display("FAIL rand_rdata_b dut%0d cyc%0d: got %h want %h", d, c, rd_b[d], ed[d][1]);
                end
            end
        end
        idle();
        step();
        step();
    endtask

    task automatic test_async_reset();
        idle();
        set_a(1, 4'd2, 32'hCAFEF00D, 4'hF);
        step();
        set_a(0, 4'd2, '0, 4'h0);
        step();
        idle();
        checks++;
        if (rv_a[0] !== 1'b1 || rd_a[0] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL async_pre_read: rvalid=%b rdata=%h want 1/cafef00d", rv_a[0], rd_a[0]);
        end
        #2;
        rst = 1;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rdy[d] !== 1'b0 || rv_a[d] !== 1'b0 || rd_a[d] !== '0 || col[d] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset dut%0d: rdy=%b rva=%b rda=%h col=%b, want all zero",
                         d, rdy[d], rv_a[d], rd_a[d], col[d]);
            end
        end
        step();
        rst = 0;
    endtask

    task automatic test_clear();
        int n;
        int bad_rv;
        idle();
        rst = 1;
        step();
        rst = 0;
        set_b(0, 4'd2, '0, 4'h0);
        n = 0;
        bad_rv = 0;
        while (rdy[0] !== 1'b1 && n < 40) begin
            step();
            n++;
            for (int d = 0; d < 3; d++)
                if (rv_b[d] !== 1'b0) bad_rv++;
        end
        idle();
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL clear_len: ready low for %0d cycles, want %0d", n, DEPTH);
        end
        checks++;
        if (bad_rv != 0) begin
            errors++;
            $display("FAIL clear_drop_b: %0d rvalid_b pulses during clear, want 0", bad_rv);
        end
        for (int i = 0; i < DEPTH; i++) begin
            set_a(0, AW'(i), '0, 4'h0);
            step();
            checks++;
            if (rv_a[0] !== 1'b1 || rd_a[0] !== 32'h0) begin
                errors++;
                $display("FAIL clear_zero addr%0d: rvalid=%b rdata=%h want 1/00000000", i, rv_a[0], rd_a[0]);
            end
        end
        idle();
        step();
        checks++;
        if (rv_a[1] !== 1'b1 || rd_a[1] !== 32'h0) begin
            errors++;
            $display("FAIL clear_zero_outreg: rvalid=%b rdata=%h want 1/00000000", rv_a[1], rd_a[1]);
        end
    endtask

    task automatic test_byte_mask();
        idle();
        set_a(1, 4'd3, 32'hDEADBEEF, 4'hF);
        step();
        set_a(1, 4'd3, 32'h11223344, 4'h5);
        step();
        idle();
        set_b(0, 4'd3, '0, 4'h0);
        step();
        idle();
        checks++;
        if (rv_b[0] !== 1'b1 || rd_b[0] !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL bmask_lat1: rvalid=%b rdata=%h want 1/de22be44", rv_b[0], rd_b[0]);
        end
        checks++;
        if (rv_b[1] !== 1'b0) begin
            errors++;
            $display("FAIL bmask_outreg_early: rvalid=%b want 0", rv_b[1]);
        end
        step();
        checks++;
        if (rv_b[1] !== 1'b1 || rd_b[1] !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL bmask_lat2: rvalid=%b rdata=%h want 1/de22be44", rv_b[1], rd_b[1]);
        end
        checks++;
        if (rv_b[0] !== 1'b0 || rd_b[0] !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL bmask_hold: rvalid=%b rdata=%h want 0/de22be44", rv_b[0], rd_b[0]);
        end
    endtask

    task automatic test_rd_mode();
        logic [DW-1:0] held;
        idle();
        set_a(1, 4'd5, 32'hAAAAAAAA, 4'hF);
        step();
        idle();
        step();
        step();
        held = ed[2][0];
        set_a(1, 4'd5, 32'h12345678, 4'hF);
        step();
        idle();
        checks++;
        if (rv_a[0] !== 1'b1 || rd_a[0] !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL mode0_old: rvalid=%b rdata=%h want 1/aaaaaaaa", rv_a[0], rd_a[0]);
        end
        checks++;
        if (rv_a[2] !== 1'b0 || rd_a[2] !== held) begin
            errors++;
            $display("FAIL mode2_nochange: rvalid=%b rdata=%h want 0/%h", rv_a[2], rd_a[2], held);
        end
        step();
        checks++;
        if (rv_a[1] !== 1'b1 || rd_a[1] !== 32'h12345678) begin
            errors++;
            $display("FAIL mode1_new: rvalid=%b rdata=%h want 1/12345678", rv_a[1], rd_a[1]);
        end
    endtask

    task automatic test_collision();
        int pulses;
        for (int r = 0; r < 2; r++) begin
            idle();
            set_a(1, 4'd7, 32'h0, 4'hF);
            step();
            set_a(1, 4'd7, 32'h000000AA, 4'h1);
            set_b(1, 4'd7, 32'h0000BBCC, (r == 0) ? 4'h3 : 4'h2);
            step();
            idle();
            pulses = (col[0] === 1'b1) ? 1 : 0;
            step();
            if (col[0] === 1'b1) pulses++;
            step();
            if (col[0] === 1'b1) pulses++;
            checks++;
            if (pulses != ((r == 0) ? 1 : 0)) begin
                errors++;
                $display("FAIL collision_pulse round%0d: %0d pulses, want %0d", r, pulses, (r == 0) ? 1 : 0);
            end
            set_a(0, 4'd7, '0, 4'h0);
            step();
            idle();
            checks++;
            if (rv_a[0] !== 1'b1 || rd_a[0] !== 32'h0000BBAA) begin
                errors++;
                $display("FAIL collision_data round%0d: rvalid=%b rdata=%h want 1/0000bbaa", r, rv_a[0], rd_a[0]);
            end
        end
    endtask

    task automatic test_cross_port();
        idle();
        set_a(1, 4'd9, 32'h1, 4'hF);
        step();
        idle();
        step();
        set_a(1, 4'd9, 32'h2, 4'hF);
        set_b(0, 4'd9, '0, 4'h0);
        step();
        idle();
        for (int d = 0; d < 3; d += 2) begin
            checks++;
            if (rv_b[d] !== 1'b1 || rd_b[d] !== 32'h1) begin
                errors++;
                $display("FAIL cross_old dut%0d: rvalid=%b rdata=%h want 1/00000001", d, rv_b[d], rd_b[d]);
            end
        end
        set_b(0, 4'd9, '0, 4'h0);
        step();
        idle();
        checks++;
        if (rv_b[0] !== 1'b1 || rd_b[0] !== 32'h2) begin
            errors++;
            $display("FAIL cross_new: rvalid=%b rdata=%h want 1/00000002", rv_b[0], rd_b[0]);
        end
        checks++;
        if (rv_b[1] !== 1'b1 || rd_b[1] !== 32'h1) begin
            errors++;
            $display("FAIL cross_old_outreg: rvalid=%b rdata=%h want 1/00000001", rv_b[1], rd_b[1]);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        idle();
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 8; i++) step();
        rst = 1;
        model_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (rdy[d] !== 1'b0 || rv_a[d] !== 1'b0 || rv_b[d] !== 1'b0 || col[d] !== 1'b0 ||
                rd_a[d] !== '0 || rd_b[d] !== '0) begin
                errors++;
                $display("FAIL midclear_zero dut%0d: rdy=%b rva=%b rvb=%b col=%b rda=%h rdb=%h, want zero",
                         d, rdy[d], rv_a[d], rv_b[d], col[d], rd_a[d], rd_b[d]);
            end
        end
        step();
        rst = 0;
        n = 0;
        while (rdy[0] !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL midclear_len: ready low for %0d cycles, want %0d", n, DEPTH);
        end
    endtask

    initial begin
        idle();
        for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
        test_reset();
        test_random();
        test_async_reset();
        test_clear();
        test_byte_mask();
        test_rd_mode();
        test_collision();
        test_cross_port();
        test_random();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
